// File: rtl/mips_test_sequencer.sv
// On-chip test harness for the pipelined MIPS32 core: loads program and expected
// register table from a host port, runs the core to HALT or timeout, then compares registers.
module mips_test_sequencer #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned IMEM_DEPTH = 64,
  parameter int unsigned NCHECK     = 8,
  parameter int unsigned TIMEOUT    = 1024,
  localparam int unsigned IMEM_AW   = $clog2(IMEM_DEPTH),
  localparam int unsigned CYC_W     = $clog2(TIMEOUT + 1)
) (
  input  logic               clk1,
  input  logic               rst,
  input  logic               clear,
  input  logic               load_valid,
  output logic               load_ready,
  input  logic               load_kind,
  input  logic [DATA_W-1:0]  load_data,
  input  logic               start,
  output logic               imem_we,
  output logic [IMEM_AW-1:0] imem_addr,
  output logic [DATA_W-1:0]  imem_wdata,
  output logic               cpu_rst,
  output logic               cpu_run,
  input  logic               cpu_halted,
  output logic [4:0]         rf_raddr,
  input  logic [DATA_W-1:0]  rf_rdata,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic               timed_out,
  output logic               overflow,
  output logic [5:0]         fail_count,
  output logic [4:0]         first_fail,
  output logic [CYC_W-1:0]   cycles
);

  localparam int unsigned PC_W  = IMEM_AW + 1;
  localparam int unsigned EX_AW = (NCHECK > 1) ? $clog2(NCHECK) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_CHECK, S_DONE} state_t;

  state_t            state;
  logic [PC_W-1:0]   prog_cnt;
  logic [5:0]        exp_cnt;
  logic [5:0]        chk_idx;
  logic              launch;
  logic              start_pend;
  logic [DATA_W-1:0] exp_mem [NCHECK];

  logic       hs;
  logic       prog_full;
  logic       exp_full;
  logic       hs_exp;
  logic       go;
  logic       mism;
  logic [5:0] fail_next;

  assign hs        = load_valid & load_ready;
  assign prog_full = (prog_cnt == PC_W'(IMEM_DEPTH));
  assign exp_full  = (exp_cnt == 6'(NCHECK));
  assign hs_exp    = hs & load_kind & ~exp_full;
  assign go        = start | start_pend;

  // Program words go straight to the core's instruction memory in the handshake cycle.
  assign imem_we    = hs & ~load_kind & ~prog_full;
  assign imem_addr  = prog_cnt[IMEM_AW-1:0];
  assign imem_wdata = load_data;

  // rf_rdata belongs to the address issued on the previous CHECK cycle.
  assign mism = (state == S_CHECK) && (chk_idx != 6'd0) &&
                (rf_rdata != exp_mem[EX_AW'(chk_idx - 6'd1)]);
  assign fail_next = fail_count + {5'd0, mism};

  always_ff @(posedge clk1) begin
    if (hs_exp) exp_mem[EX_AW'(exp_cnt)] <= load_data;
  end

  always_ff @(posedge clk1) begin
    if (rst) begin
      state      <= S_IDLE;
      prog_cnt   <= '0;
      exp_cnt    <= '0;
      chk_idx    <= '0;
      launch     <= 1'b0;
      start_pend <= 1'b0;
      load_ready <= 1'b1;
      cpu_rst    <= 1'b1;
      cpu_run    <= 1'b0;
      rf_raddr   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      timed_out  <= 1'b0;
      overflow   <= 1'b0;
      fail_count <= '0;
      first_fail <= '0;
      cycles     <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (clear) begin
            state      <= S_IDLE;
            prog_cnt   <= '0;
            exp_cnt    <= '0;
            start_pend <= 1'b0;
            overflow   <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            timed_out  <= 1'b0;
            fail_count <= '0;
            first_fail <= '0;
            cycles     <= '0;
          end else begin
            if (hs) begin
              if (!load_kind) begin
                if (prog_full) overflow <= 1'b1;
                else           prog_cnt <= prog_cnt + PC_W'(1);
              end else begin
                if (exp_full) overflow <= 1'b1;
                else          exp_cnt  <= exp_cnt + 6'd1;
              end
            end
            if (go && hs) begin
              // Load wins this cycle; the run launches on the next one.
              start_pend <= 1'b1;
              state      <= S_IDLE;
              done       <= 1'b0;
            end else if (go) begin
              start_pend <= 1'b0;
              state      <= S_RUN;
              launch     <= 1'b1;
              load_ready <= 1'b0;
              cpu_rst    <= 1'b1;
              cpu_run    <= 1'b0;
              busy       <= 1'b1;
              done       <= 1'b0;
              pass       <= 1'b0;
              timed_out  <= 1'b0;
              fail_count <= '0;
              first_fail <= '0;
              cycles     <= '0;
            end else if (hs) begin
              state <= S_IDLE;
              done  <= 1'b0;
            end
          end
        end

        S_RUN: begin
          if (launch) begin
            launch  <= 1'b0;
            cpu_rst <= 1'b0;
            cpu_run <= 1'b1;
          end else if (cpu_halted) begin
            cpu_run  <= 1'b0;
            state    <= S_CHECK;
            chk_idx  <= '0;
            rf_raddr <= '0;
          end else if (cycles == CYC_W'(TIMEOUT)) begin
            timed_out <= 1'b1;
            cpu_run   <= 1'b0;
            state     <= S_CHECK;
            chk_idx   <= '0;
            rf_raddr  <= '0;
          end else begin
            cycles <= cycles + CYC_W'(1);
          end
        end

        S_CHECK: begin
          if (mism) begin
            fail_count <= fail_next;
            if (fail_count == 6'd0) first_fail <= 5'(chk_idx - 6'd1);
          end
          if (chk_idx == exp_cnt) begin
            state      <= S_DONE;
            busy       <= 1'b0;
            done       <= 1'b1;
            pass       <= (fail_next == 6'd0) && !timed_out;
            cpu_rst    <= 1'b1;
            load_ready <= 1'b1;
          end else begin
            chk_idx  <= chk_idx + 6'd1;
            rf_raddr <= 5'(chk_idx + 6'd1);
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_test_sequencer.sv
// Bench for mips_test_sequencer: behavioural core stub (IMEM, regfile, ADDI/ADD/OR/HALT)
// plus table-driven, hand-written and randomized runs against an arithmetic reference.
module tb_mips_test_sequencer;
  localparam int unsigned DW = 32;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned NCK = 8;
  localparam int unsigned TMO = 50;
  localparam int unsigned AW = 4;
  localparam int unsigned CW = 6;

  logic          clk1 = 1'b0;
  logic          rst = 1'b1;
  logic          clear = 1'b0;
  logic          load_valid = 1'b0;
  logic          load_ready;
  logic          load_kind = 1'b0;
  logic [DW-1:0] load_data = '0;
  logic          start = 1'b0;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [DW-1:0] imem_wdata;
  logic          cpu_rst;
  logic          cpu_run;
  logic          cpu_halted;
  logic [4:0]    rf_raddr;
  logic [DW-1:0] rf_rdata = '0;
  logic          busy, done, pass, timed_out, overflow;
  logic [5:0]    fail_count;
  logic [4:0]    first_fail;
  logic [CW-1:0] cycles;

  mips_test_sequencer #(.DATA_W(DW), .IMEM_DEPTH(DEPTH), .NCHECK(NCK), .TIMEOUT(TMO)) dut (
    .clk1(clk1), .rst(rst), .clear(clear), .load_valid(load_valid), .load_ready(load_ready),
    .load_kind(load_kind), .load_data(load_data), .start(start), .imem_we(imem_we),
    .imem_addr(imem_addr), .imem_wdata(imem_wdata), .cpu_rst(cpu_rst), .cpu_run(cpu_run),
    .cpu_halted(cpu_halted), .rf_raddr(rf_raddr), .rf_rdata(rf_rdata), .busy(busy),
    .done(done), .pass(pass), .timed_out(timed_out), .overflow(overflow),
    .fail_count(fail_count), .first_fail(first_fail), .cycles(cycles)
  );

  always #5 clk1 = ~clk1;

  // Core stub: one instruction per enabled cycle, register read data one cycle late.
  logic [31:0] imem [DEPTH];
  logic [31:0] regs [32];
  logic [AW-1:0] pc = '0;
  logic halted = 1'b0;
  int run_cnt = 0;
  int halt_after = 0;
  int we_cnt = 0;
  wire [31:0] ins = imem[pc];

  assign cpu_halted = halted | (halt_after != 0 && run_cnt == halt_after);

  always @(posedge clk1) if (imem_we) imem[imem_addr] <= imem_wdata;
  always @(posedge clk1) if (imem_we) we_cnt <= we_cnt + 1;

  always @(posedge clk1) begin
    rf_rdata <= regs[rf_raddr];
    if (cpu_rst) begin
      pc <= '0;
      halted <= 1'b0;
      run_cnt <= 0;
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (cpu_run) begin
      run_cnt <= run_cnt + 1;
      if (!halted) begin
        if (ins[31:26] == 6'h3f) halted <= 1'b1;
        else begin
          if (ins[31:26] == 6'h08 && ins[20:16] != 5'd0)
            regs[ins[20:16]] <= regs[ins[25:21]] + {{16{ins[15]}}, ins[15:0]};
          else if (ins[31:26] == 6'h00 && ins[15:11] != 5'd0 && ins[5:0] == 6'h20)
            regs[ins[15:11]] <= regs[ins[25:21]] + regs[ins[20:16]];
          else if (ins[31:26] == 6'h00 && ins[15:11] != 5'd0 && ins[5:0] == 6'h25)
            regs[ins[15:11]] <= regs[ins[25:21]] | regs[ins[20:16]];
          pc <= pc + 1'b1;
        end
      end
    end
  end

  int checks = 0;
  int errors = 0;
  int bad_ready = 0;

  localparam logic [31:0] OR7  = 32'h00E73825;
  localparam logic [31:0] HALT = 32'hFC000000;
  logic [31:0] main_prog [8] = '{32'h2001000A, 32'h20020014, 32'h20030019, OR7, OR7,
                                 32'h00222020, OR7, HALT};

  typedef struct {
    int          n;
    logic [31:0] ev [NCK];
    bit          pass;
    int          fc;
    int          ff;
  } vec_t;
  vec_t tbl [6];

  task automatic step();
    @(posedge clk1);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  task automatic load_word(input logic kind, input logic [31:0] d);
    load_valid = 1'b1;
    load_kind = kind;
    load_data = d;
    step();
    load_valid = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  task automatic load_main();
    for (int i = 0; i < 8; i++) load_word(1'b0, main_prog[i]);
  endtask

  task automatic wait_done();
    for (int c = 0; c < 400; c++) begin
      step();
      if (busy && load_ready) bad_ready++;
      if (done) break;
    end
    start = 1'b0;
    load_valid = 1'b0;
    chk("run_reaches_done", done, 1);
  endtask

  // disturb: keep start and an expected-value load asserted for the whole run
  task automatic run(input bit disturb);
    start = 1'b1;
    step();
    if (disturb) begin
      load_valid = 1'b1;
      load_kind = 1'b1;
      load_data = 32'hDEAD_BEEF;
    end else start = 1'b0;
    wait_done();
  endtask

  task automatic check_result(input string nm, input bit p, input int fc, input int ff,
                              input bit to);
    chk({nm, "_pass"}, pass, p);
    chk({nm, "_fail_count"}, fail_count, fc);
    chk({nm, "_first_fail"}, first_fail, ff);
    chk({nm, "_timed_out"}, timed_out, to);
  endtask

  initial begin
    logic [31:0] rprog [$];
    logic [31:0] rref [32];
    logic [31:0] rexp [NCK];
    int rn, rfc, rff;
    for (int i = 0; i < int'(DEPTH); i++) imem[i] = '0;
    for (int i = 0; i < 32; i++) regs[i] = '0;

    tbl[0] = '{5, '{0, 10, 20, 25, 30, 0, 0, 0}, 1'b1, 0, 0};
    tbl[1] = '{5, '{0, 10, 20, 25, 31, 0, 0, 0}, 1'b0, 1, 4};
    tbl[2] = '{0, '{7, 7, 7, 7, 7, 7, 7, 7},     1'b1, 0, 0};
    tbl[3] = '{3, '{1, 10, 21, 0, 0, 0, 0, 0},   1'b0, 2, 0};
    tbl[4] = '{8, '{0, 10, 20, 25, 30, 0, 0, 0}, 1'b1, 0, 0};
    tbl[5] = '{5, '{0, 11, 20, 26, 30, 0, 0, 0}, 1'b0, 2, 1};

    // reset state
    repeat (3) step();
    chk("rst_load_ready", load_ready, 1);
    chk("rst_cpu_rst", cpu_rst, 1);
    chk("rst_cpu_run", cpu_run, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_fail_count", fail_count, 0);
    chk("rst_cycles", cycles, 0);
    rst = 1'b0;
    step();

    // table-driven runs of the reference program
    for (int t = 0; t < 6; t++) begin
      do_clear();
      load_main();
      for (int i = 0; i < tbl[t].n; i++) load_word(1'b1, tbl[t].ev[i]);
      run(1'b0);
      check_result($sformatf("tbl%0d", t), tbl[t].pass, tbl[t].fc, tbl[t].ff, 1'b0);
      chk($sformatf("tbl%0d_cycles_lt40", t), (cycles < 40 && cycles != 0), 1);
    end

    // start during RUN and loads during CHECK are ignored
    do_clear();
    load_main();
    for (int i = 0; i < tbl[1].n; i++) load_word(1'b1, tbl[1].ev[i]);
    bad_ready = 0;
    run(1'b1);
    check_result("disturb", 1'b0, 1, 4, 1'b0);
    chk("disturb_ready_low_when_busy", bad_ready, 0);
    chk("disturb_done_held", done, 1);
    run(1'b0);
    check_result("disturb_rerun", 1'b0, 1, 4, 1'b0);

    // start coinciding with a load handshake: load taken, start deferred by one cycle
    do_clear();
    load_main();
    for (int i = 0; i < 4; i++) load_word(1'b1, tbl[0].ev[i]);
    load_valid = 1'b1; load_kind = 1'b1; load_data = 32'd30; start = 1'b1;
    step();
    load_valid = 1'b0; start = 1'b0;
    chk("defer_busy_low", busy, 0);
    step();
    chk("defer_busy_high", busy, 1);
    chk("defer_cpu_rst", cpu_rst, 1);
    wait_done();
    check_result("defer", 1'b1, 0, 0, 1'b0);

    // randomized ADDI programs against an arithmetic reference
    for (int it = 0; it < 20; it++) begin
      int k;
      rprog.delete();
      for (int i = 0; i < 32; i++) rref[i] = '0;
      k = $urandom_range(1, 6);
      for (int i = 0; i < k; i++) begin
        logic [4:0] rs, rt;
        logic [15:0] imm;
        rs = 5'($urandom_range(0, 7));
        rt = 5'($urandom_range(1, 7));
        imm = 16'($urandom);
        rprog.push_back({6'h08, rs, rt, imm});
        rref[rt] = rref[rs] + 32'(signed'(imm));
      end
      rprog.push_back(HALT);
      rn = $urandom_range(0, NCK);
      rfc = 0;
      rff = 0;
      for (int i = 0; i < rn; i++) begin
        rexp[i] = rref[i];
        if ($urandom_range(0, 9) < 3) begin
          rexp[i] = rexp[i] ^ (32'd1 << $urandom_range(0, 31));
          if (rfc == 0) rff = i;
          rfc++;
        end
      end
      do_clear();
      foreach (rprog[i]) load_word(1'b0, rprog[i]);
      for (int i = 0; i < rn; i++) load_word(1'b1, rexp[i]);
      run(1'b0);
      check_result($sformatf("rand%0d", it), rfc == 0, rfc, rff, 1'b0);
    end

    // program overflow, then timeout on a program with no HALT
    do_clear();
    begin
      int we0;
      we0 = we_cnt;
      for (int i = 0; i < int'(DEPTH) + 2; i++) load_word(1'b0, OR7);
      chk("ovf_flag", overflow, 1);
      chk("ovf_we_pulses", we_cnt - we0, DEPTH);
    end
    load_word(1'b1, 32'd0);
    load_word(1'b1, 32'd5);
    run(1'b0);
    check_result("timeout", 1'b0, 1, 1, 1'b1);
    chk("timeout_cycles", cycles, TMO);
    do_clear();
    chk("clear_overflow", overflow, 0);
    chk("clear_done", done, 0);
    chk("clear_timed_out", timed_out, 0);
    chk("clear_cycles", cycles, 0);
    for (int i = 0; i < int'(NCK) + 1; i++) load_word(1'b1, 32'd0);
    chk("exp_ovf_flag", overflow, 1);

    // HALT in the same cycle the timeout would fire: HALT wins
    halt_after = TMO;
    run(1'b0);
    halt_after = 0;
    check_result("halt_vs_timeout", 1'b1, 0, 0, 1'b0);
    chk("halt_vs_timeout_cycles", cycles, TMO);

    // rst mid-run, then rerun the retained program with an emptied expected table
    do_clear();
    load_main();
    for (int i = 0; i < tbl[1].n; i++) load_word(1'b1, tbl[1].ev[i]);
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (4) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_cpu_rst", cpu_rst, 1);
    chk("midrst_cpu_run", cpu_run, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_load_ready", load_ready, 1);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("rerun_busy", busy, 1);
    chk("rerun_cpu_rst_pulse", cpu_rst, 1);
    chk("rerun_cpu_run_off", cpu_run, 0);
    step();
    chk("rerun_cpu_rst_low", cpu_rst, 0);
    chk("rerun_cpu_run_on", cpu_run, 1);
    wait_done();
    check_result("rerun", 1'b1, 0, 0, 1'b0);
    chk("rerun_cycles_lt40", (cycles < 40 && cycles != 0), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mips_test_sequencer.md
Name: mips_test_sequencer

Overview:
- Parametrised, synthesizable on-chip test harness for the pipelined MIPS32 core.
- Streams a program image and a table of expected register values from a host port, then writes the program into the core's instruction memory.
- Releases the core, waits for HALT or a cycle timeout, then reads back registers R0..R(N-1) and reports pass/fail with diagnostics.

Parameters:
- DATA_W, 32, width of instruction, register and expected-value words
- IMEM_DEPTH, 64, instruction memory words; IMEM_AW = clog2(IMEM_DEPTH)
- NCHECK, 8, maximum number of registers compared (R0..R(NCHECK-1)); 1..32
- TIMEOUT, 1024, run-phase cycle limit; counter width CYC_W = clog2(TIMEOUT+1)

Ports:
- clk1  in  1  sole clock (core runs from the same clock domain)
- rst  in  1  synchronous, active-high reset
- clear  in  1  clears load counters and results; accepted only in IDLE or DONE
- load_valid  in  1  host word valid
- load_ready  out  1  sequencer accepts word
- load_kind  in  1  0 = program word, 1 = expected value
- load_data  in  DATA_W  host word
- start  in  1  one-cycle pulse to begin a run
- imem_we  out  1  instruction memory write strobe
- imem_addr  out  IMEM_AW  instruction memory write address
- imem_wdata  out  DATA_W  instruction word
- cpu_rst  out  1  core reset (PC=0, HALTED=0, TAKEN_BRANCH=0)
- cpu_run  out  1  core clock-enable
- cpu_halted  in  1  core HALTED flag
- rf_raddr  out  5  register-file read address
- rf_rdata  in  DATA_W  register read data, valid one cycle after rf_raddr
- busy  out  1  high in RUN or CHECK
- done  out  1  high in DONE
- pass  out  1  all compared registers matched and no timeout; valid while done
- timed_out  out  1  run ended by TIMEOUT
- overflow  out  1  a load word was dropped
- fail_count  out  6  number of mismatching registers
- first_fail  out  5  index of the first mismatch; 0 if none
- cycles  out  CYC_W  run-phase cycle count

Behaviour:
- Reset values:
  - load_ready=1, cpu_rst=1.
  - All other outputs 0.
  - prog_cnt=0, exp_cnt=0, state=IDLE.
- States:
  - IDLE: loading allowed.
  - RUN: core executing.
  - CHECK: register compare.
  - DONE: results held.
- Load (IDLE or DONE):
  - load_ready=1.
  - The handshake completes when load_valid and load_ready are both high.
  - Program word: same cycle, imem_we=1, imem_addr=prog_cnt, imem_wdata=load_data; prog_cnt increments.
  - Expected word: stored at exp_mem[exp_cnt]; exp_cnt increments.
  - Word arriving with prog_cnt==IMEM_DEPTH (or exp_cnt==NCHECK): dropped, overflow set sticky until clear/rst; no wrap-around.
  - A load accepted in DONE moves the state to IDLE; results are kept until start.
- load_ready=0 in RUN and CHECK.
- clear: zeroes prog_cnt, exp_cnt, overflow and all result outputs; state becomes IDLE. Ignored in RUN/CHECK.
- start (IDLE or DONE only; ignored elsewhere):
  - Next cycle: results cleared, cpu_rst=1 for exactly one cycle, cycles=0, state=RUN.
  - start in the same cycle as a load handshake: the load is accepted first; start takes effect next cycle.
- RUN:
  - cpu_rst=0, cpu_run=1, cycles increments every cycle.
  - cpu_halted=1 → cpu_run drops the next cycle, state=CHECK.
  - cycles==TIMEOUT without HALT → timed_out=1, state=CHECK.
  - HALT and timeout in the same cycle → HALT wins, timed_out=0.
- CHECK:
  - cpu_run=0 and cpu_rst=0; core register file is held.
  - Issue rf_raddr=i for i=0..exp_cnt-1, one per cycle.
  - Compare rf_rdata with exp_mem[i] one cycle later, pipelined.
  - Each mismatch increments fail_count; the first mismatch latches first_fail.
  - Duration exp_cnt+1 cycles; with exp_cnt==0 it is one cycle and nothing is compared.
- DONE:
  - done=1; pass = (fail_count==0) & ~timed_out.
  - cpu_rst=1 held, so the core stays reset between runs.
- rst mid-run: returns to reset values immediately, including cpu_rst=1 and cpu_run=0; loaded program in IMEM is not erased.

Test Plan:
- Load program ADDI R1,R0,10 / ADDI R2,R0,20 / ADDI R3,R0,25 / OR×2 / ADD R4,R1,R2 / OR / HALT (8 words) and expected {0,10,20,25,30}, then start → done=1, pass=1, fail_count=0, timed_out=0, cycles < 40.
- Same program, expected R4=31 → pass=0, fail_count=1, first_fail=4.
- Program without HALT, TIMEOUT=50 → timed_out=1 at cycles=50, pass=0; compare phase still runs.
- Stream IMEM_DEPTH+2 program words → last two dropped, overflow=1, imem_we pulses exactly IMEM_DEPTH times; clear → overflow=0.
- Assert start during RUN, and load_valid during CHECK → both ignored (load_ready=0); results identical to an undisturbed run.
- Assert rst mid-RUN, then start again without reloading → cpu_rst pulses, identical pass result (IMEM retained; expected table requires reload since exp_cnt=0 → pass=1 with zero compares).
